// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM memory controller: RAM status codes,
// controller states and the common data word.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IREAD  = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } ctrl_state_t;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Grant selector between icache and dcache requests, evaluated only in IDLE.
// ROUND_ROBIN_EN adds a last-grant register; otherwise dcache has fixed priority.
module mem_arb_sel (
`ifdef ROUND_ROBIN_EN
  input  logic CLK,
  input  logic nRST,
`endif
  input  logic arb_en,
  input  logic ireq,
  input  logic dreq,
  output logic gnt_i,
  output logic gnt_d
);

`ifdef ROUND_ROBIN_EN
  // Set when the dcache received the most recent grant; reset favours icache
  // as "last", so the dcache wins the first contention.
  logic last_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d <= 1'b0;
    end else if (arb_en && (ireq || dreq)) begin
      last_d <= gnt_d;
    end
  end

  always_comb begin
    gnt_d = arb_en && dreq && (!ireq || !last_d);
    gnt_i = arb_en && ireq && !gnt_d;
  end
`else
  always_comb begin
    gnt_d = arb_en && dreq;
    gnt_i = arb_en && ireq && !dreq;
  end
`endif

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder arbitrating icache/dcache requests onto one RAM port.
// Optional round-robin arbitration is enabled with the ROUND_ROBIN_EN macro.
module cache_mem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  ctrl_state_t       state;
  ctrl_state_t       next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic dreq;
  logic gnt_i;
  logic gnt_d;
  logic access;
  logic i_abort;
  logic d_abort;

  assign dreq   = dREN || dWEN;
  assign access = (ramstate_t'(ramstate) == ACCESS);

  // An icache request that changes address or drops is abandoned; an aborted
  // read never completes, even if the RAM reports ACCESS in the same cycle.
  assign i_abort = (state == IREAD) && (!iREN || (iaddr != addr_q));
  assign d_abort = (state == DREAD) && !dreq;

  mem_arb_sel u_arb (
`ifdef ROUND_ROBIN_EN
    .CLK    (CLK),
    .nRST   (nRST),
`endif
    .arb_en (state == IDLE),
    .ireq   (iREN),
    .dreq   (dreq),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (gnt_d) begin
      addr_q <= daddr;
      data_q <= dWEN ? dstore : '0;
    end else if (gnt_i) begin
      addr_q <= iaddr;
      data_q <= '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (gnt_d) begin
          next_state = dWEN ? DWRITE : DREAD;
        end else if (gnt_i) begin
          next_state = IREAD;
        end
      end
      IREAD: begin
        if (i_abort || access) begin
          next_state = IDLE;
        end
      end
      DREAD: begin
        if (d_abort || access) begin
          next_state = IDLE;
        end
      end
      DWRITE: begin
        if (access) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IREAD: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (access && !i_abort) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (access && !d_abort) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = addr_q;
        ramstore = data_q;
        if (access) begin
          dwait = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level grant/memory model.
module tb_cache_mem_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int checks = 0;
  int errors = 0;

  word_t mem [int];
  bit    last_d;

  cache_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Arbitration rule: single requester wins; with both pending, dcache wins
  // under fixed priority, or the side not granted last under round robin.
  function automatic bit pick_d(input bit pi, input bit pd);
`ifdef ROUND_ROBIN_EN
    if (pi && pd) return !last_d;
`endif
    return pd;
  endfunction

  function automatic logic [1:0] rand_stall();
    int unsigned r;
    r = $urandom_range(0, 2);
    if (r == 0) return FREE;
    if (r == 1) return BUSY;
    return ERROR;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".ren"}, ramREN, 0);
    chk({tag, ".wen"}, ramWEN, 0);
    chk({tag, ".iwait"}, iwait, 1);
    chk({tag, ".dwait"}, dwait, 1);
    chk({tag, ".iload"}, iload, 0);
    chk({tag, ".dload"}, dload, 0);
  endtask

  // Runs one or two requests to completion; stalls < 0 means random stall
  // count, stall_rs < 0 means random non-ACCESS status each stall cycle.
  task automatic run_txn(input bit want_i, input bit want_d, input bit wr,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] dd, input int stalls, input int stall_rs);
    bit pend_i;
    bit pend_d;
    bit g_d;
    bit is_wr;
    int k;
    logic [31:0] a;
    logic [31:0] rd;
    pend_i = want_i;
    pend_d = want_d;
    iREN   = want_i;
    iaddr  = ia;
    dWEN   = want_d && wr;
    dREN   = want_d && (wr ? 1'($urandom_range(0, 1)) : 1'b1);
    daddr  = da;
    dstore = dd;
    while (pend_i || pend_d) begin
      g_d    = pick_d(pend_i, pend_d);
      last_d = g_d;
      is_wr  = g_d && wr;
      a      = g_d ? da : ia;
      ramstate = FREE;
      ramload  = $urandom;
      settle();
      check_idle("idle");
      tick();
      k = (stalls < 0) ? int'($urandom_range(0, 3)) : stalls;
      for (int s = 0; s < k; s++) begin
        ramstate = (stall_rs < 0) ? rand_stall() : 2'(stall_rs);
        ramload  = $urandom;
        settle();
        chk("stall.ren", ramREN, !is_wr);
        chk("stall.wen", ramWEN, is_wr);
        chk("stall.addr", ramaddr, a);
        chk("stall.store", ramstore, is_wr ? dd : 32'h0);
        chk("stall.iwait", iwait, 1);
        chk("stall.dwait", dwait, 1);
        chk("stall.iload", iload, 0);
        chk("stall.dload", dload, 0);
        tick();
      end
      ramstate = ACCESS;
      if (is_wr) begin
        ramload = $urandom;
        rd      = 32'h0;
      end else begin
        if (!mem.exists(int'(a))) mem[int'(a)] = $urandom;
        rd      = mem[int'(a)];
        ramload = rd;
      end
      settle();
      chk("acc.ren", ramREN, !is_wr);
      chk("acc.wen", ramWEN, is_wr);
      chk("acc.addr", ramaddr, a);
      chk("acc.store", ramstore, is_wr ? dd : 32'h0);
      chk("acc.iwait", iwait, g_d);
      chk("acc.dwait", dwait, !g_d);
      chk("acc.iload", iload, g_d ? 32'h0 : rd);
      chk("acc.dload", dload, g_d ? rd : 32'h0);
      if (is_wr) mem[int'(a)] = dd;
      tick();
      if (g_d) begin
        dREN = 0; dWEN = 0; pend_d = 0;
      end else begin
        iREN = 0; pend_i = 0;
      end
    end
    ramstate = FREE;
  endtask

  initial begin
    bit g_d;
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 32'hFFFF_FFFF; ramstate = ACCESS;
    last_d = 0;
    #3;
    chk("rst.iwait", iwait, 1);
    chk("rst.dwait", dwait, 1);
    chk("rst.ren", ramREN, 0);
    chk("rst.wen", ramWEN, 0);
    chk("rst.addr", ramaddr, 0);
    chk("rst.store", ramstore, 0);
    chk("rst.iload", iload, 0);
    chk("rst.dload", dload, 0);
    ramstate = FREE;
    tick();
    nRST = 1;
    tick();

    // icache read with two BUSY cycles, then dcache write beating icache
    mem[32'h40] = 32'hDEADBEEF;
    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 2, BUSY);
    run_txn(1, 1, 1, 32'h48, 32'h80, 32'h12345678, 1, BUSY);
    chk("wr.mem", mem[32'h80], 32'h12345678);
    // dcache read held through three ERROR cycles
    run_txn(0, 1, 0, 32'h0, 32'h100, 32'h0, 3, ERROR);

    // icache abort on address change
    iREN = 1; iaddr = 32'h40; ramstate = FREE; last_d = 0;
    tick();
    ramstate = BUSY; settle();
    chk("iab.ren", ramREN, 1);
    chk("iab.addr", ramaddr, 32'h40);
    tick();
    iaddr = 32'h44; settle();
    chk("iab.iwait0", iwait, 1);
    tick();
    ramstate = ACCESS; settle();
    chk("iab.idle_ren", ramREN, 0);
    chk("iab.idle_iwait", iwait, 1);
    chk("iab.idle_iload", iload, 0);
    tick();
    ramload = 32'hCAFE0044; settle();
    chk("iab.reissue_ren", ramREN, 1);
    chk("iab.reissue_addr", ramaddr, 32'h44);
    chk("iab.iwait", iwait, 0);
    chk("iab.iload", iload, 32'hCAFE0044);
    tick();
    iREN = 0; ramstate = FREE;

    // dcache read abort when both dREN and dWEN drop
    dREN = 1; daddr = 32'h100; last_d = 1;
    tick();
    ramstate = BUSY; settle();
    chk("dab.ren", ramREN, 1);
    tick();
    dREN = 0; settle();
    chk("dab.dwait0", dwait, 1);
    tick();
    ramstate = ACCESS; settle();
    chk("dab.idle_ren", ramREN, 0);
    chk("dab.dwait", dwait, 1);
    chk("dab.dload", dload, 0);
    tick();
    ramstate = FREE;

    // reset in the middle of a write
    dWEN = 1; daddr = 32'h80; dstore = 32'hAAAA5555; last_d = 1;
    tick();
    ramstate = BUSY; settle();
    chk("rstw.wen_before", ramWEN, 1);
    nRST = 0; #1;
    chk("rstw.wen", ramWEN, 0);
    chk("rstw.dwait", dwait, 1);
    chk("rstw.iwait", iwait, 1);
    chk("rstw.addr", ramaddr, 0);
    chk("rstw.store", ramstore, 0);
    dWEN = 0; ramstate = ACCESS; last_d = 0;
    tick();
    nRST = 1;
    tick();
    settle();
    chk("rstw.after_wen", ramWEN, 0);
    chk("rstw.after_dwait", dwait, 1);
    tick();
    ramstate = FREE;

    // continuous requests from both caches
    iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300;
    for (int n = 0; n < 4; n++) begin
      g_d    = pick_d(1, 1);
      last_d = g_d;
      ramstate = FREE; settle();
      chk("cont.idle_ren", ramREN, 0);
      tick();
      ramstate = ACCESS; ramload = 32'h1000 + n; settle();
      chk("cont.dwait", dwait, !g_d);
      chk("cont.iwait", iwait, g_d);
      chk("cont.addr", ramaddr, g_d ? 32'h300 : 32'h200);
      tick();
    end
    iREN = 0; dREN = 0; ramstate = FREE;
    tick();

    for (int t = 0; t < 40; t++) begin
      int unsigned sel;
      sel = $urandom_range(1, 3);
      run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2,
              $urandom, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
